rotate_undo: RTL and testbench
==============================

# rotate_undo

Iterative inverse rotator: accepts a 32-bit rotated word with its rotate amount and direction, and rotates it back the opposite way to recover the original word. It sits downstream of the single-round rotate datapath, on the return path. It undoes a `K`-bit rotate in `right` direction, so a word passed through the rotate round and then this block comes back unchanged. Transfers use valid/ready handshakes on both sides, and the block processes one word at a time.

## Interface
- `WIDTH`, 32, data word width; fixed at 32, since `K` is 5 bits.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  input word, `K` and `right` are valid
- `in_ready`  out  1  block can accept input; high only in IDLE
- `F`  in  32  rotated word to be undone
- `K`  in  5  rotate amount originally applied, 0..31
- `right`  in  1  1 = original rotate was right (undo rotates left); 0 = original was left (undo rotates right)
- `out_valid`  out  1  `A` holds the recovered word
- `out_ready`  in  1  consumer accepts `A`
- `A`  out  32  recovered word, registered
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, load the data register with `F`, the count with `K`, and the direction flag with `right`.
  - If `K`==0 (slow mode), go to DONE; otherwise go to RUN.
- RUN (slow mode):
  - Each cycle, rotate the data register 1 bit in the undo direction and decrement the count.
  - When the decremented count reaches 0, go to DONE.
- DONE:
  - `out_valid`=1 and `A` is stable.
  - On `out_ready`, go to IDLE.
  - A new input is never accepted in the same cycle as output completion.
- `A` is the data register. It is updated only during RUN and on load, and it keeps its last value in IDLE.
- Rotation is modulo 32 and bits wrap around. `K`=31 is equivalent to a 1-bit rotate in the opposite direction; slow mode still takes 31 cycles for it.
- `F`, `K` and `right` are ignored outside the accept cycle.

## Timing
- Reset values: state=IDLE, `A`=0, `out_valid`=0, `busy`=0, `in_ready`=1. Reset is asynchronous and applies immediately.
- Slow-mode latency, with the accept edge at cycle t: `out_valid` rises at cycle t+1+`K`. For `K`=0 it rises at t+1.
- `in_ready` is low from t+1 until the cycle after the output handshake.
- Output handshake completes on the edge where `out_valid`&`out_ready`. `in_ready`=1 on the next cycle.
- With `out_ready` held low, DONE persists indefinitely with `A` frozen.
- Reset mid-RUN or mid-DONE:
  - Return to IDLE.
  - The in-flight word is discarded.
  - `A`=0.
  - No `out_valid` is produced for that word.

## Configuration
- `ROTATE_UNDO_FAST_EN`:
  - Defined: RUN always lasts exactly 5 cycles. In step i (i=0..4), rotate by 2^i in the undo direction if bit i of the loaded `K` is 1, otherwise hold. `out_valid` rises at t+6 for every `K`, including 0, because the K==0 shortcut is disabled.
  - Undefined: the 1-bit-per-cycle behaviour described above, with latency 1+`K`.
- Results are identical in both modes; only latency differs.

## Test plan
- `F`=0x7FFF8000, `K`=1, `right`=1 -> `A`=0xFFFF0000. Slow: `out_valid` at t+2; fast: at t+6.
- `F`=0xFFFE0001, `K`=1, `right`=0 -> `A`=0xFFFF0000. Repeat with `K`=31, `right`=1, `F`=0xFFFE0001 -> `A`=0xFFFF0000; slow mode takes 32 cycles.
- `F`=0x00110000, `K`=4, `right`=0 -> `A`=0x00011000, `out_valid` at t+5 in slow mode.
- `F`=0x12345678, `K`=0 -> `A`=0x12345678; slow: `out_valid` at t+1; fast: at t+6.
- Backpressure:
  - Hold `out_ready`=0 for 3 cycles in DONE -> `A` stable, `out_valid`=1, `in_ready`=0 throughout.
  - `in_valid` held high with a new word during this time -> not accepted until the cycle after the output handshake.
- Assert `rst_n`=0 mid-RUN (`K`=20, 5 cycles after accept) -> `A`=0, `out_valid`=0, `in_ready`=1 immediately. The next transaction completes correctly.

Source files
------------

// File: rtl/rotate_undo.sv
// rotate_undo: iterative inverse rotator with valid/ready handshakes on both sides.
// Undoes a K-bit rotate: right=1 means the original rotate was right, so this block
// rotates left; right=0 means it rotates right. One word is in flight at a time.
// Optional build macro ROTATE_UNDO_FAST_EN: log-step mode, where RUN always takes 5 cycles
// and step i rotates by 2^i when bit i of K is set. Undefined: 1 bit per cycle, K cycles.
module rotate_undo #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] F,
   input  logic [4:0]       K,
   input  logic             right,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] A,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q;
   logic [WIDTH-1:0]  data_q;
   logic [4:0]        cnt_q;
   logic              dir_q;   // 1: undo rotates left
`ifdef ROTATE_UNDO_FAST_EN
   logic [2:0]        step_q;
`endif

   // Rotate a 32-bit word by amt positions; the doubled word makes the wrap-around free.
   function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] d,
                                            input logic [4:0]       amt,
                                            input logic             left);
      logic [2*WIDTH-1:0] t;
      if (left) begin
         t = {d, d} << amt;
         return t[2*WIDTH-1:WIDTH];
      end else begin
         t = {d, d} >> amt;
         return t[WIDTH-1:0];
      end
   endfunction

   // Control FSM and datapath registers; A is the data register itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         data_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
`ifdef ROTATE_UNDO_FAST_EN
         step_q  <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  data_q <= F;
                  cnt_q  <= K;
                  dir_q  <= right;
`ifdef ROTATE_UNDO_FAST_EN
                  step_q  <= '0;
                  state_q <= StRun;
`else
                  // Nothing to undo for K==0, so skip straight to the result.
                  state_q <= (K == 5'd0) ? StDone : StRun;
`endif
               end
            end
            StRun: begin
`ifdef ROTATE_UNDO_FAST_EN
               // Step i contributes a 2^i rotate when bit i of the loaded amount is set.
               if (cnt_q[step_q]) begin
                  data_q <= rot(data_q, 5'd1 << step_q, dir_q);
               end
               step_q <= step_q + 3'd1;
               if (step_q == 3'd4) begin
                  state_q <= StDone;
               end
`else
               data_q <= rot(data_q, 5'd1, dir_q);
               cnt_q  <= cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  state_q <= StDone;
               end
`endif
            end
            StDone: begin
               if (out_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Handshake and status outputs decode directly from the state register.
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
      busy      = (state_q != StIdle);
      A         = data_q;
   end

endmodule

// File: tb/tb_rotate_undo.sv
// Scoreboard bench for rotate_undo: the stimulus process pushes the expected word and
// latency on issue; a negedge monitor pops and compares whenever out_valid appears.
module tb_rotate_undo;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] F;
   logic [4:0]  K;
   logic        right;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] A;
   logic        busy;

   rotate_undo #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .F         (F),
      .K         (K),
      .right     (right),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .A         (A),
      .busy      (busy)
   );

   typedef struct {
      logic [31:0] a;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   hs_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   function automatic int exp_lat(input int k);
`ifdef ROTATE_UNDO_FAST_EN
      return 6;
`else
      return 1 + k;
`endif
   endfunction

   // Monitor: latency counted from the negedge where the accept is visible.
   int          acc_cyc = 0;
   bit          seen_valid = 0;
   bit          post_hs = 0;
   logic [31:0] hold_a;
   exp_t        cur;

   always @(negedge clk) begin
      if (!rst_n) begin
         seen_valid = 0;
         post_hs    = 0;
      end else begin
         if (post_hs) begin
            chk("in_ready_after_hs", {30'd0, in_ready, out_valid}, 32'd2);
            post_hs = 0;
         end
         if (out_valid) begin
            if (!seen_valid) begin
               seen_valid = 1;
               hold_a     = A;
               if (exp_q.size() == 0) begin
                  chk("unexpected_output", 32'd1, 32'd0);
               end else begin
                  cur = exp_q.pop_front();
                  chk("result", A, cur.a);
                  chk("latency", 32'(cyc - acc_cyc), 32'(cur.lat));
               end
            end else begin
               chk("a_stable", A, hold_a);
            end
            chk("in_ready_low_done", {31'd0, in_ready}, 32'd0);
            if (out_ready) begin
               seen_valid = 0;
               post_hs    = 1;
               hs_cnt++;
            end
         end
         if (in_valid && in_ready) acc_cyc = cyc;
      end
   end

   task automatic push(input logic [31:0] a, input int k);
      exp_t e;
      e.a   = a;
      e.lat = exp_lat(k);
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic [31:0] f, input logic [4:0] k, input logic r);
      bit ok = 0;
      @(posedge clk); #1;
      F = f; K = k; right = r; in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) chk("accept_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1; break; end
      end
      if (!ok) chk("valid_timeout", 32'd1, 32'd0);
   endtask

   task automatic finish_out(input int hold);
      repeat (hold) @(posedge clk);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic txn(input logic [31:0] f, input logic [4:0] k, input logic r,
                      input logic [31:0] a, input int hold);
      push(a, int'(k));
      drive(f, k, r);
      wait_valid();
      finish_out(hold);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      F = '0; K = '0; right = 1'b0;
      #1;
      chk("rst_A", A, 32'd0);
      chk("rst_flags", {29'd0, out_valid, busy, in_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      txn(32'h7FFF8000, 5'd1,  1'b1, 32'hFFFF0000, 0);
      txn(32'hFFFE0001, 5'd1,  1'b0, 32'hFFFF0000, 0);
      txn(32'hFFFE0001, 5'd31, 1'b1, 32'hFFFF0000, 0);
      txn(32'h00110000, 5'd4,  1'b0, 32'h00011000, 0);
      txn(32'h12345678, 5'd0,  1'b0, 32'h12345678, 0);

      // Backpressure with the next word already waiting on the input.
      push(32'h00000180, 8);
      push(32'h0000000F, 12);
      drive(32'h80000001, 5'd8, 1'b1);
      wait_valid();
      @(posedge clk); #1;
      F = 32'h0000F000; K = 5'd12; right = 1'b0; in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp_next_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      F = 32'hFFFFFFFF;
      wait_valid();
      finish_out(0);

      // Reset five cycles into a K=20 run; the word must vanish.
      drive(32'hA5A5A5A5, 5'd20, 1'b1);
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrun_A", A, 32'd0);
      chk("midrun_flags", {29'd0, out_valid, busy, in_ready}, 32'd1);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("midrun_no_output", {31'd0, out_valid}, 32'd0);

      txn(32'hDEADBEEF, 5'd16, 1'b1, 32'hBEEFDEAD, 0);

      repeat (3) @(posedge clk);
      chk("handshakes", 32'(hs_cnt), 32'd8);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
